// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the fifo_ctrl block.
package fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AF_LEVEL = 6;
    localparam int DEF_AE_LEVEL = 2;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int ADDR_W = addr_w(DEF_DEPTH);

endpackage

// File: rtl/occ_counter.sv
// Occupancy counter: +1 on inc alone, -1 on dec alone, hold otherwise.
module occ_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !dec) begin
            r_count <= r_count + ONE;
        end else if (dec && !inc) begin
            r_count <= r_count - ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO with registered read port, occupancy flags and sticky error flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [addr_w(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = addr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] PTR_1  = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;
    logic [CNT_W-1:0]  w_count;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Flags come straight from the registered count; acceptance uses pre-edge flags only.
    assign full         = (w_count == FULL_C);
    assign empty        = (w_count == '0);
    assign almost_full  = (w_count >= AF_C);
    assign almost_empty = (w_count <= AE_C);

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    occ_counter #(
        .CNT_W (CNT_W)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_wr_acc),
        .dec   (w_rd_acc),
        .count (w_count)
    );

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_1;
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_1;
            end
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = w_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl against a queue-based reference model.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0] q [$];
    logic       m_ov;
    logic       m_un;
    logic       m_vld;
    logic [7:0] m_data;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_vld));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_data));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_un));
    endtask

    // One clock: drive inputs, advance the model by the same edge, compare.
    task automatic cyc(input string tag, input logic w, input logic r,
                       input logic [7:0] d, input logic rs);
        logic was_full;
        logic was_empty;
        rst     = rs;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_ov   = 1'b0;
            m_un   = 1'b0;
            m_vld  = 1'b0;
            m_data = 8'h00;
        end else begin
            was_full  = (q.size() == 8);
            was_empty = (q.size() == 0);
            if (w && was_full) m_ov = 1'b1;
            if (r && was_empty) m_un = 1'b1;
            m_vld = r && !was_empty;
            if (m_vld) m_data = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        chk_all(tag);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] dv;
        logic [7:0] exp_next;
        q.delete();
        m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0; m_data = 8'h00;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        cyc("reset0", 1'b0, 1'b0, 8'h00, 1'b1);
        cyc("reset1", 1'b1, 1'b1, 8'hAA, 1'b1);
        chk("reset.empty_const", 32'(empty), 32'd1);

        // Fill with 0x11..0x18, then a rejected ninth write.
        for (int i = 0; i < 8; i++) begin
            cyc("fill", 1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
            chk("fill.afull_edge", 32'(almost_full), 32'(i >= 5));
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count8", 32'(count), 32'd8);
        cyc("ovf", 1'b1, 1'b0, 8'h99, 1'b0);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.count8", 32'(count), 32'd8);

        // Drain in order, then a rejected ninth read.
        for (int i = 0; i < 8; i++) begin
            cyc("drain", 1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain.data", 32'(rd_data), 32'(8'h11 + i));
            chk("drain.vld", 32'(rd_valid), 32'd1);
        end
        chk("drain.empty", 32'(empty), 32'd1);
        cyc("udf", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf.flag", 32'(underflow), 32'd1);
        chk("udf.vld", 32'(rd_valid), 32'd0);

        // Steady state at count 4 with simultaneous traffic across several wraps.
        cyc("rst2", 1'b0, 1'b0, 8'h00, 1'b1);
        dv = 8'h40;
        for (int i = 0; i < 4; i++) begin
            cyc("pre4", 1'b1, 1'b0, dv, 1'b0);
            dv++;
        end
        exp_next = 8'h40;
        for (int i = 0; i < 20; i++) begin
            cyc("both4", 1'b1, 1'b1, dv, 1'b0);
            dv++;
            chk("both4.count", 32'(count), 32'd4);
            chk("both4.order", 32'(rd_data), 32'(exp_next));
            exp_next++;
        end

        // Simultaneous read/write when full, then when empty.
        for (int i = 0; i < 4; i++) begin
            cyc("top", 1'b1, 1'b0, dv, 1'b0);
            dv++;
        end
        cyc("full_rw", 1'b1, 1'b1, 8'hEE, 1'b0);
        chk("full_rw.count7", 32'(count), 32'd7);
        chk("full_rw.ovf", 32'(overflow), 32'd1);
        chk("full_rw.vld", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 7; i++) cyc("empty_out", 1'b0, 1'b1, 8'h00, 1'b0);
        cyc("empty_rw", 1'b1, 1'b1, 8'h5A, 1'b0);
        chk("empty_rw.count1", 32'(count), 32'd1);
        chk("empty_rw.udf", 32'(underflow), 32'd1);
        chk("empty_rw.vld", 32'(rd_valid), 32'd0);

        // Reset mid-operation with a write pending discards everything.
        cyc("rst3", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        cyc("rst_wr", 1'b1, 1'b0, 8'hFF, 1'b1);
        chk("rst_wr.count0", 32'(count), 32'd0);
        chk("rst_wr.ovf0", 32'(overflow), 32'd0);
        cyc("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_rd.vld", 32'(rd_valid), 32'd0);
        chk("post_rst_rd.udf", 32'(underflow), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
